// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
// The master drives operations and mthi/mtlo writes; the slave returns status and HI/LO.
interface mips_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, operand_a, operand_b, hi_we, lo_we,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, hi_we, lo_we,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit: one bit per cycle over 32 RUN cycles,
// sign fix-up and HI/LO write in a single FINISH cycle.
module mips_muldiv_unit (
  input  logic          clk,
  input  logic          reset,
  mips_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg;
  logic [63:0] work_reg;
  logic [31:0] operand_reg;
  logic        is_div_reg;
  logic        neg_low_reg;
  logic        neg_rem_reg;
  logic        dbz_pending_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        done_reg;
  logic        dbz_reg;

  logic        accept;
  logic        finish;

  // Operand magnitudes; negating 0x80000000 wraps to itself, read as unsigned.
  logic        signed_op;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    signed_op = bus.op[0];
    mag_a = (signed_op && bus.operand_a[31]) ? (32'd0 - bus.operand_a) : bus.operand_a;
    mag_b = (signed_op && bus.operand_b[31]) ? (32'd0 - bus.operand_b) : bus.operand_b;
  end

  // Multiply step: work = {partial product, remaining multiplier bits}.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  // Divide step: work = {remainder, dividend bits shifting into quotient}.
  logic [32:0] div_trial;
  logic        div_fits;
  logic [31:0] div_rem;
  logic [63:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, work_reg[63:32]} + {1'b0, (work_reg[0] ? operand_reg : 32'd0)};
    mul_next  = {mul_sum, work_reg[31:1]};
    div_trial = {work_reg[63:32], work_reg[31]};
    div_fits  = (div_trial >= {1'b0, operand_reg});
    div_rem   = div_fits ? (div_trial[31:0] - operand_reg) : div_trial[31:0];
    div_next  = {div_rem, work_reg[30:0], div_fits};
  end

  // Sign correction applied in FINISH.
  logic [63:0] prod_signed;
  logic [31:0] quot_signed, rem_signed;

  always_comb begin
    prod_signed = neg_low_reg ? (64'd0 - work_reg) : work_reg;
    quot_signed = neg_low_reg ? (32'd0 - work_reg[31:0]) : work_reg[31:0];
    rem_signed  = neg_rem_reg ? (32'd0 - work_reg[63:32]) : work_reg[63:32];
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (count_reg == 5'd31) state_next = FINISH;
      end
      FINISH: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg       <= '0;
      work_reg        <= '0;
      operand_reg     <= '0;
      is_div_reg      <= 1'b0;
      neg_low_reg     <= 1'b0;
      neg_rem_reg     <= 1'b0;
      dbz_pending_reg <= 1'b0;
      hi_reg          <= '0;
      lo_reg          <= '0;
      done_reg        <= 1'b0;
      dbz_reg         <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        // Multiply and divide share the same initial layout: {0, mag_a}.
        count_reg       <= '0;
        work_reg        <= {32'd0, mag_a};
        operand_reg     <= mag_b;
        is_div_reg      <= bus.op[1];
        neg_low_reg     <= signed_op && (bus.operand_a[31] ^ bus.operand_b[31]);
        neg_rem_reg     <= signed_op && bus.operand_a[31];
        dbz_pending_reg <= bus.op[1] && (bus.operand_b == 32'd0);
        dbz_reg         <= 1'b0;
      end else if (state_reg == RUN) begin
        work_reg  <= is_div_reg ? div_next : mul_next;
        count_reg <= count_reg + 5'd1;
      end else if (finish) begin
        done_reg <= 1'b1;
        if (is_div_reg) begin
          dbz_reg <= dbz_pending_reg;
          if (!dbz_pending_reg) begin
            hi_reg <= rem_signed;
            lo_reg <= quot_signed;
          end
        end else begin
          hi_reg <= prod_signed[63:32];
          lo_reg <= prod_signed[31:0];
        end
      end else if (state_reg == IDLE) begin
        if (bus.hi_we) hi_reg <= bus.operand_a;
        if (bus.lo_we) lo_reg <= bus.operand_a;
      end
    end
  end

  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;

endmodule
